// File: rtl/vga_console_portb_arb.sv
// vga_console_portb_arb
// Arbitrates RAM port B of the console character/attribute RAM between the
// host bus and a clear/scroll engine. The engine either fills the text area
// with a fill word, or scrolls it up one row and blanks the last row.
//
// Ports:
//   clk, rst                       clock (also RAM port B clock), sync active-high reset
//   host_valid/ready/addr/wstrobe/wdata   host access request (wstrobe==0 is a read)
//   host_rdata/host_rvalid         read data, valid the cycle after an accepted read
//   cmd_clear/cmd_scroll/fill_word command pulses and fill value
//   cmd_busy/cmd_done              engine active / one-cycle completion pulse
//   ram_addr/ram_wstrobe/ram_wdata/ram_rdata   RAM port B (1-cycle read latency)
//
// Build option: VGA_ARB_HOST_INTERLEAVE_EN lets the host steal port B while
// the engine runs; the engine stalls for each stolen cycle.
//
// state  | meaning
// IDLE   | host owns port B, commands accepted
// CLR    | write fill word to word idx
// SCR_RD | read word idx+ROW_WORDS
// SCR_WR | write word idx with the word just read
// FILL   | blank last row with fill word
// DONE   | one-cycle cmd_done pulse
module vga_console_portb_arb #(
  parameter int ADDR_WIDTH = 10,
  parameter int ROW_WORDS  = 40,
  parameter int ROWS       = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [3:0]            host_wstrobe,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata,
  output logic                  host_rvalid,
  input  logic                  cmd_clear,
  input  logic                  cmd_scroll,
  input  logic [31:0]           fill_word,
  output logic                  cmd_busy,
  output logic                  cmd_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_wstrobe,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int IW = ADDR_WIDTH + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_SCR_RD = 3'd2;
  localparam logic [2:0] S_SCR_WR = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [IW-1:0]         LAST_WORD  = IW'(ROWS * ROW_WORDS - 1);
  localparam logic [IW-1:0]         SCR_LAST   = IW'((ROWS - 1) * ROW_WORDS - 1);
  localparam logic [IW-1:0]         FILL_START = IW'((ROWS - 1) * ROW_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ROW_OFS    = ADDR_WIDTH'(ROW_WORDS);

  logic [2:0]            state;
  logic [IW-1:0]         idx;
  logic [31:0]           fillReg;
  logic [31:0]           holdReg;
  logic                  engRdPrev;
  logic                  rvalidReg;
  logic [ADDR_WIDTH-1:0] lastAddr;
  logic [31:0]           lastWdata;

  logic                  hostFire;
  logic                  engActive;
  logic                  engStall;
  logic [31:0]           scrData;
  logic [ADDR_WIDTH-1:0] addrC;
  logic [3:0]            strobeC;
  logic [31:0]           wdataC;

`ifdef VGA_ARB_HOST_INTERLEAVE_EN
  assign host_ready = 1'b1;
`else
  assign host_ready = (state == S_IDLE);
`endif

  assign hostFire  = host_valid && host_ready;
  assign engActive = (state == S_CLR) || (state == S_SCR_RD) ||
                     (state == S_SCR_WR) || (state == S_FILL);
  // Only reachable with interleave enabled; otherwise host_ready is low here.
  assign engStall  = hostFire && engActive;

  // Read data arrives the cycle after SCR_RD; a steal in between parks it in holdReg.
  assign scrData = engRdPrev ? ram_rdata : holdReg;

  always_comb begin
    addrC   = lastAddr;
    strobeC = 4'b0000;
    wdataC  = lastWdata;
    if (rst) begin
      // Keep the RAM quiet while reset is held, even mid-command.
      addrC  = '0;
      wdataC = '0;
    end else if (hostFire) begin
      addrC   = host_addr;
      strobeC = host_wstrobe;
      wdataC  = host_wdata;
    end else begin
      case (state)
        S_CLR, S_FILL: begin
          addrC   = idx[ADDR_WIDTH-1:0];
          strobeC = 4'b1111;
          wdataC  = fillReg;
        end
        S_SCR_RD: addrC = idx[ADDR_WIDTH-1:0] + ROW_OFS;
        S_SCR_WR: begin
          addrC   = idx[ADDR_WIDTH-1:0];
          strobeC = 4'b1111;
          wdataC  = scrData;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      fillReg   <= '0;
      holdReg   <= '0;
      engRdPrev <= 1'b0;
      rvalidReg <= 1'b0;
      lastAddr  <= '0;
      lastWdata <= '0;
    end else begin
      rvalidReg <= hostFire && (host_wstrobe == 4'b0000);
      engRdPrev <= (state == S_SCR_RD) && !engStall;
      if (engRdPrev) holdReg <= ram_rdata;
      lastAddr  <= addrC;
      lastWdata <= wdataC;
      if (!engStall) begin
        case (state)
          S_IDLE: begin
            if (cmd_clear) begin
              state   <= S_CLR;
              fillReg <= fill_word;
              idx     <= '0;
            end else if (cmd_scroll) begin
              state   <= S_SCR_RD;
              fillReg <= fill_word;
              idx     <= '0;
            end
          end
          S_CLR, S_FILL: begin
            if (idx == LAST_WORD) state <= S_DONE;
            else                  idx   <= idx + 1'b1;
          end
          S_SCR_RD: state <= S_SCR_WR;
          S_SCR_WR: begin
            if (idx < SCR_LAST) begin
              idx   <= idx + 1'b1;
              state <= S_SCR_RD;
            end else begin
              idx   <= FILL_START;
              state <= S_FILL;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign host_rdata  = ram_rdata;
  assign host_rvalid = rvalidReg;
  assign cmd_busy    = engActive;
  assign cmd_done    = (state == S_DONE);
  assign ram_addr    = addrC;
  assign ram_wstrobe = strobeC;
  assign ram_wdata   = wdataC;

endmodule

// File: doc/vga_console_portb_arb.md
# vga_console_portb_arb

Port-B controller for the console's dual-port character/attribute RAM. It shares the RAM's read/write port between a host bus and a built-in clear/scroll engine. The engine either fills the whole text area with a fill word or scrolls it up one row and blanks the last row. Port A (video scan-out) is untouched; this block sits between the host bus decoder and the RAM's RW port.

## Interface
- ADDR_WIDTH, 10, RAM word-address width
- ROW_WORDS, 40, 32-bit words per text row
- ROWS, 25, text rows; ROWS*ROW_WORDS <= 2**ADDR_WIDTH; text area starts at word 0
- clk  in  1  sole clock, also drives RAM port B
- rst  in  1  synchronous, active-high reset
- host_valid  in  1  host access request
- host_ready  out  1  access accepted when host_valid && host_ready
- host_addr  in  ADDR_WIDTH  word address
- host_wstrobe  in  4  byte write enables; 4'b0000 = read
- host_wdata  in  32  write data
- host_rdata  out  32  read data
- host_rvalid  out  1  read data valid pulse
- cmd_clear  in  1  start clear, 1-cycle pulse
- cmd_scroll  in  1  start scroll-up, 1-cycle pulse
- fill_word  in  32  fill value, sampled at command start
- cmd_busy  out  1  engine active
- cmd_done  out  1  1-cycle completion pulse
- ram_addr  out  ADDR_WIDTH  to RAM port B
- ram_wstrobe  out  4  to RAM port B
- ram_wdata  out  32  to RAM port B
- ram_rdata  in  32  from RAM port B, registered, 1-cycle latency

## Operation
- States: IDLE, CLR, SCR_RD, SCR_WR, FILL, DONE.
- IDLE: host_ready=1. An accepted access drives ram_addr/ram_wstrobe/ram_wdata combinationally from the host_* inputs.
- Command start, IDLE only: cmd_clear wins over cmd_scroll. Latch fill_word, clear the word index i. Commands while not IDLE are ignored.
- CLR: write fill to word i, all strobes. i++ each granted cycle. After i=ROWS*ROW_WORDS-1 go to DONE.
- SCR_RD: read address i+ROW_WORDS, go to SCR_WR.
- SCR_WR: write word i, all strobes, with the word read in SCR_RD. i++.
  - If i < (ROWS-1)*ROW_WORDS-1, go to SCR_RD.
  - Else go to FILL with i=(ROWS-1)*ROW_WORDS.
- FILL: write fill to word i. After the last word go to DONE.
- DONE: cmd_done=1 for one cycle, then IDLE.
- Idle port: when neither engine nor host drives port B, ram_wstrobe=0 and ram_addr holds its last value.
- Host reads: host_rdata=ram_rdata. host_rvalid=1 the cycle after an accepted read, never after writes or engine reads.
- Hold register: loaded from ram_rdata in every cycle that follows an engine read. SCR_WR writes ram_rdata if it executes in the cycle right after SCR_RD, else the hold register.
- Counters: i is ADDR_WIDTH+1 bits wide, so there is no wrap.

## Timing
- Reset values: host_ready=1, host_rvalid=0, host_rdata follows ram_rdata, cmd_busy=0, cmd_done=0, ram_wstrobe=0, ram_addr=0, ram_wdata=0, state IDLE.
- cmd_busy=1 from the cycle after the command pulse through the last write cycle inclusive. cmd_done pulses in the next cycle.
- Unstalled busy length:
  - Clear: ROWS*ROW_WORDS cycles.
  - Scroll: 2*(ROWS-1)*ROW_WORDS + ROW_WORDS cycles.
- Host access and command pulse in the same IDLE cycle: both are taken. The host access executes that cycle and the engine starts next cycle.
- Reset mid-command: abort to IDLE immediately. RAM is left partially updated and no cmd_done is issued.
- host_ready depends only on state and config, never combinationally on host_valid.

## Configuration
- VGA_ARB_HOST_INTERLEAVE_EN defined:
  - host_ready=1 in all states.
  - An accepted host access takes port B that cycle and the engine stalls: no state or index change, ram_* come from the host.
  - The hold register preserves scroll data across steals.
  - Busy length grows by one cycle per steal.
- Undefined: host_ready=0 in CLR/SCR_RD/SCR_WR/FILL/DONE, and the host waits for the command to complete.

## Test plan
Use ADDR_WIDTH=4, ROW_WORDS=4, ROWS=3.
- Reset, then host write 0x11223344 to address 5 with strobe 4'b0101, then read address 5 → RAM word 5 = 0x00220044 over prior zero; host_rvalid one cycle after the read, host_rdata=0x00220044.
- cmd_clear with fill_word=0xA5A5A5A5 → cmd_busy high exactly 12 cycles, cmd_done one pulse, words 0..11 = 0xA5A5A5A5, words 12..15 unchanged.
- Preload word k = k for k=0..11, cmd_scroll with fill_word=0x20 → words 0..7 = 4..11, words 8..11 = 0x20, busy for 20 cycles.
- Interleave disabled: host_valid held during a scroll → host_ready=0 until DONE; the access completes in the first IDLE cycle.
- Interleave enabled: host write to word 14 on the cycle after each SCR_RD during a scroll → scroll result identical to the previous test, word 14 written, busy extended by the number of steals.
- Reset asserted on the 5th busy cycle of a clear → IDLE next cycle, no cmd_done, words 0..3 filled, words 4..11 untouched.
